fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the IF stage. It owns the program counter and drives a single-outstanding request/acknowledge handshake to instruction memory. It places each fetched word into a one-entry output buffer that ID consumes. It also handles downstream stall and branch/jump redirect (flush), including a redirect that arrives while a memory request is in flight.

## Interface
Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; first fetch address.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high (`RSTENABLE`).
- stall  in  1  ID cannot accept an instruction this cycle.
- flush  in  1  redirect request; valid for exactly the cycle it is high.
- branch_target  in  32  new PC when flush=1; bits [1:0] ignored (forced 0).
- ce  out  1  instruction-memory chip enable; `CHIPDISABLE` in S_IDLE, `CHIPENABLE` otherwise.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc, or the latched in-flight address in S_DROP.
- imem_ack  in  1  memory accepted request and imem_rdata valid this cycle; ignored when imem_req=0.
- imem_rdata  in  32  fetched word.
- inst_valid  out  1  output buffer holds an instruction.
- inst  out  32  buffered instruction.
- inst_pc  out  32  address of the buffered instruction.

## Operation
- Registers: pc (32), state (2), inst, inst_pc, inst_valid, ce.
- Consume event: inst_valid && !stall. The buffer is free this cycle if !inst_valid or a consume occurs.
- The state machine has four states:
  - S_IDLE: entered on reset. imem_req=0, ce=0. Next cycle → S_FETCH, ce←1.
  - S_FETCH:
    - imem_req = buffer free.
    - If imem_req && imem_ack: inst←imem_rdata, inst_pc←pc, inst_valid←1, pc←pc+4 (mod 2^32).
    - If the buffer is not free: → S_HOLD.
    - If imem_req && !imem_ack: remain; imem_addr must stay stable.
  - S_HOLD: imem_req=0. On a consume: inst_valid←0, → S_FETCH.
  - S_DROP: the request is in flight but a flush was taken.
    - imem_req=1 and imem_addr=latched old address until imem_ack.
    - On ack, discard the data, → S_FETCH at the new pc.
- Flush has highest priority after rst:
  - pc←{branch_target[31:2],2'b00}; inst_valid←0.
  - From S_FETCH with imem_req=1 and no ack this cycle: latch old address, → S_DROP.
  - From S_FETCH with ack this cycle: discard the returned word, stay in S_FETCH.
  - From S_HOLD or S_DROP: → S_FETCH, or stay in S_DROP if its ack is still pending.
  - From S_IDLE: pc updated, → S_FETCH as normal.
- Flush together with stall: flush wins; the buffer is cleared regardless of stall.
- A consume and a new ack in the same cycle: the buffer is overwritten with the new word and inst_valid stays 1.

## Timing
- Reset values: pc=RESET_PC, state=S_IDLE, ce=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- rst is sampled at posedge and overrides everything.
- Reset mid-request drops imem_req the next cycle; memory must tolerate an abandoned request.
- Cycle 0: rst released. Cycle 1: S_IDLE, ce=0. Cycle 2: imem_req=1, addr=RESET_PC.
- With a zero-wait memory (ack in the request cycle), inst_valid=1 at cycle 3.
- Steady state with a zero-wait memory and no stall: one instruction per cycle.
- N wait cycles add N cycles per fetch.
- Flush to first new request: 1 cycle if no request is in flight; otherwise 1 cycle after the in-flight ack.
- Outputs imem_req and imem_addr are combinational from state, pc and buffer status. All other outputs are registered.

## Structure
- The shared macro header macro.v holds:
  - the existing `RSTENABLE`, `CHIPENABLE` and `CHIPDISABLE` constants;
  - new state encodings S_IDLE/S_FETCH/S_HOLD/S_DROP;
  - `PC_STEP` (4).
- Single module; no sub-module. The output buffer is too small to justify one.

## Test plan
- Reset then zero-wait memory returning addr+1000 as data, stall=0 → req at cycle 2 with addr 0; inst_valid at cycle 3; inst_pc sequence 0,4,8,…; inst 1000,1004,….
- Memory with 2 wait cycles → imem_addr held stable during the wait; one instruction every 3 cycles; pc advances only on ack.
- stall=1 for 5 cycles while inst_valid=1 → goes to S_HOLD with imem_req=0 and inst/inst_pc unchanged; resumes fetching the next sequential pc after stall drops.
- flush with branch_target=32'h00000103 while idle-fetching → next request address 32'h00000100; buffer cleared the same cycle.
- flush while a 3-wait request to 0x20 is pending → req stays high with addr 0x20 until ack; that data is never presented; next request goes to the target.
- rst asserted mid-wait-request, then released → imem_req=0 and ce=0 after the next posedge; refetch starts at RESET_PC with the normal 2-cycle latency.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the IF stage: reset/chip-enable polarities, FSM encodings, PC step.
package fetch_ctrl_pkg;

  localparam logic RSTENABLE   = 1'b1;
  localparam logic CHIPENABLE  = 1'b1;
  localparam logic CHIPDISABLE = 1'b0;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  // Redirect targets are word aligned; the low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch: owns pc, single-outstanding req/ack to imem, one-entry output buffer.
// Latency: first request 1 cycle after leaving reset idle; zero-wait memory gives inst_valid the cycle after ack.
// Backpressure: stall with a full buffer parks the FSM in S_HOLD with imem_req low until ID consumes.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        ce,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic        consume;
  logic        buf_free;
  logic        fetch_ack;

  assign consume   = inst_valid && !stall;
  assign buf_free  = !inst_valid || consume;
  assign fetch_ack = imem_req && imem_ack;

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = buf_free;
        if (flush) begin
          // An unanswered request must still be drained before redirecting.
          if (buf_free && !imem_ack) state_nxt = S_DROP;
        end else if (!buf_free) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush || consume) state_nxt = S_FETCH;
      end
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        if (imem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      pc         <= RESET_PC;
      drop_addr  <= RESET_PC;
      ce         <= CHIPDISABLE;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
    end else begin
      ce <= (state_nxt == S_IDLE) ? CHIPDISABLE : CHIPENABLE;
      if (flush) begin
        pc         <= align_pc(branch_target);
        inst_valid <= 1'b0;
        if (state == S_FETCH && imem_req && !imem_ack) drop_addr <= pc;
      end else if (state == S_FETCH && fetch_ack) begin
        // Overwrites the buffer even when ID consumes in the same cycle.
        inst       <= imem_rdata;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
        pc         <= pc + PC_STEP;
      end else if (consume) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a wait-state-configurable memory returning addr+1000.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        ce;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int tests_run = 0;
  int fails = 0;
  int mem_wait = 0;
  int mem_cnt = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch_target(branch_target),
    .ce(ce), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // Memory responds 2 time units after each edge, after the bench has driven its inputs.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        if (mem_cnt >= mem_wait) begin
          imem_ack = 1'b1;
          imem_rdata = imem_addr + 32'd1000;
          mem_cnt = 0;
        end else begin
          imem_ack = 1'b0;
          mem_cnt = mem_cnt + 1;
        end
      end else begin
        imem_ack = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Leaves the bench at +3 of the first idle cycle after reset.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    mem_wait = 0;
    do_reset();
    tests_run++; if (ce !== 1'b0) begin fails++; $display("FAIL reset_ce got=%0h exp=0", ce); end
    tests_run++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
    tests_run++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    tests_run++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0h exp=0", inst_valid); end
    tests_run++; if (inst !== 32'd0) begin fails++; $display("FAIL reset_inst got=%h exp=0", inst); end
    tests_run++; if (inst_pc !== 32'd0) begin fails++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
  endtask

  task automatic test_zero_wait();
    tick(); settle();
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin fails++; $display("FAIL zw_first_req got req=%0h addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    tests_run++; if (ce !== 1'b1) begin fails++; $display("FAIL zw_ce got=%0h exp=1", ce); end
    tests_run++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL zw_valid_c2 got=%0h exp=0", inst_valid); end
    for (int k = 0; k < 6; k++) begin
      tick(); settle();
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4*k) || inst !== 32'(4*k + 1000) || imem_addr !== 32'(4*k + 4)) begin
        fails++;
        $display("FAIL zw_stream[%0d] got v=%0h pc=%h inst=%h addr=%h exp v=1 pc=%h inst=%h addr=%h",
                 k, inst_valid, inst_pc, inst, imem_addr, 32'(4*k), 32'(4*k + 1000), 32'(4*k + 4));
      end
    end
  endtask

  task automatic test_wait2();
    mem_wait = 2;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        tick(); settle();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin
          fails++; $display("FAIL w2_addr[%0d.%0d] got req=%0h addr=%h exp req=1 addr=%h", k, w, imem_req, imem_addr, 32'(4*k));
        end
        if (k > 0) begin
          tests_run++;
          if (inst_valid !== (w == 0) || (w == 0 && inst_pc !== 32'(4*(k-1)))) begin
            fails++; $display("FAIL w2_out[%0d.%0d] got v=%0h pc=%h exp v=%0d pc=%h", k, w, inst_valid, inst_pc, (w == 0), 32'(4*(k-1)));
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    mem_wait = 0;
    do_reset();
    tick(); tick();
    stall = 1'b1;
    settle();
    tests_run++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req_drop got=%0h exp=0", imem_req); end
    for (int i = 1; i < 5; i++) begin
      tick(); settle();
      tests_run++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== 32'd1000) begin
        fails++; $display("FAIL stall_hold[%0d] got req=%0h v=%0h pc=%h inst=%h exp req=0 v=1 pc=0 inst=3e8", i, imem_req, inst_valid, inst_pc, inst);
      end
    end
    tick();
    stall = 1'b0;
    settle();
    tests_run++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin fails++; $display("FAIL stall_release got req=%0h v=%0h exp req=0 v=1", imem_req, inst_valid); end
    tick(); settle();
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'd4 || inst_valid !== 1'b0) begin fails++; $display("FAIL stall_resume_req got req=%0h addr=%h v=%0h exp req=1 addr=4 v=0", imem_req, imem_addr, inst_valid); end
    tick(); settle();
    tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'd4 || inst !== 32'd1004) begin fails++; $display("FAIL stall_resume_inst got v=%0h pc=%h inst=%h exp v=1 pc=4 inst=3ec", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_flush_idle();
    mem_wait = 0;
    do_reset();
    tick(); tick();
    flush = 1'b1; branch_target = 32'h00000103;
    settle();
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin fails++; $display("FAIL fl_cycle got req=%0h addr=%h exp req=1 addr=4", imem_req, imem_addr); end
    tick();
    flush = 1'b0;
    settle();
    tests_run++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL fl_target got v=%0h req=%0h addr=%h exp v=0 req=1 addr=100", inst_valid, imem_req, imem_addr); end
    tick(); settle();
    tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'h100 + 32'd1000) begin fails++; $display("FAIL fl_first_inst got v=%0h pc=%h inst=%h exp v=1 pc=100 inst=4e8", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_flush_stall();
    mem_wait = 0;
    do_reset();
    tick(); tick();
    stall = 1'b1;
    tick();
    flush = 1'b1; branch_target = 32'h00000040;
    settle();
    tests_run++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin fails++; $display("FAIL fs_hold got req=%0h v=%0h exp req=0 v=1", imem_req, inst_valid); end
    tick();
    flush = 1'b0;
    settle();
    tests_run++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL fs_cleared got v=%0h req=%0h addr=%h exp v=0 req=1 addr=40", inst_valid, imem_req, imem_addr); end
    tick();
    stall = 1'b0;
    settle();
    tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin fails++; $display("FAIL fs_inst got v=%0h pc=%h exp v=1 pc=40", inst_valid, inst_pc); end
  endtask

  task automatic test_flush_inflight();
    mem_wait = 0;
    do_reset();
    tick();
    flush = 1'b1; branch_target = 32'h00000020;
    settle();
    tick();
    flush = 1'b0; mem_wait = 3;
    settle();
    tests_run++; if (inst_valid !== 1'b0 || imem_addr !== 32'h20) begin fails++; $display("FAIL fi_discard got v=%0h addr=%h exp v=0 addr=20", inst_valid, imem_addr); end
    tick();
    flush = 1'b1; branch_target = 32'h00000080;
    settle();
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin fails++; $display("FAIL fi_pending got req=%0h addr=%h exp req=1 addr=20", imem_req, imem_addr); end
    tick();
    flush = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20 || inst_valid !== 1'b0) begin
        fails++; $display("FAIL fi_drop[%0d] got req=%0h addr=%h v=%0h exp req=1 addr=20 v=0", i, imem_req, imem_addr, inst_valid);
      end
      if (i == 0) begin tick(); settle(); end
    end
    tick();
    mem_wait = 0;
    settle();
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || inst_valid !== 1'b0) begin fails++; $display("FAIL fi_redirect got req=%0h addr=%h v=%0h exp req=1 addr=80 v=0", imem_req, imem_addr, inst_valid); end
    tick(); settle();
    tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst !== 32'h80 + 32'd1000) begin fails++; $display("FAIL fi_new_inst got v=%0h pc=%h inst=%h exp v=1 pc=80 inst=468", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_reset_mid();
    mem_wait = 2;
    do_reset();
    tick();
    rst = 1'b1;
    settle();
    tests_run++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rm_pre got req=%0h exp=1", imem_req); end
    tick();
    rst = 1'b0;
    settle();
    tests_run++; if (imem_req !== 1'b0 || ce !== 1'b0) begin fails++; $display("FAIL rm_drop got req=%0h ce=%0h exp req=0 ce=0", imem_req, ce); end
    tick(); settle();
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || ce !== 1'b1) begin fails++; $display("FAIL rm_refetch got req=%0h addr=%h ce=%0h exp req=1 addr=0 ce=1", imem_req, imem_addr, ce); end
    tick(); tick(); tick(); settle();
    tests_run++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst !== 32'd1000) begin fails++; $display("FAIL rm_inst got v=%0h pc=%h inst=%h exp v=1 pc=0 inst=3e8", inst_valid, inst_pc, inst); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait2();
    test_stall();
    test_flush_idle();
    test_flush_stall();
    test_flush_inflight();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
